// File: rtl/cdc_fifo_wr_ctrl.sv
// Write-domain half of a dual-clock FIFO: drives the memory write port, publishes a Gray
// write pointer and derives full/level status from the synchronized Gray read pointer.
module cdc_fifo_wr_ctrl #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk_write,
  input  logic              rst,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W:0]   rd_ptr_gray_in,
  input  logic              overflow_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   wr_ptr_gray_out,
  output logic              fifo_full,
  output logic              fifo_almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AFULL_LVL = PW'(AFULL_THRESH);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ {1'b0, b[ADDR_W:1]};
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_W:0] wr_bin_r;
  logic [ADDR_W:0] sync_r [SYNC_STAGES];
  logic [ADDR_W:0] rq_s;
  logic [ADDR_W:0] rd_bin_s;
  logic            accept_s;
  logic [ADDR_W:0] wr_bin_next_s;
  logic [ADDR_W:0] wr_gray_next_s;
  logic [ADDR_W:0] level_next_s;
  logic            full_next_s;
  logic            afull_next_s;

  // Read-pointer synchronizer chain; only the Gray pointer crosses into clk_write.
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= rd_ptr_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign rq_s = sync_r[SYNC_STAGES-1];

  // Next-state pointer and status; status uses the post-accept pointer so full is never late.
  always_comb begin
    accept_s       = write_en & ~fifo_full;
    wr_bin_next_s  = wr_bin_r + {{ADDR_W{1'b0}}, accept_s};
    wr_gray_next_s = bin2gray(wr_bin_next_s);
    rd_bin_s       = gray2bin(rq_s);
    // Full: same index, opposite wrap -> Gray differs only in its two MSBs.
    full_next_s    = (wr_gray_next_s == {~rq_s[ADDR_W:ADDR_W-1], rq_s[ADDR_W-2:0]});
    level_next_s   = wr_bin_next_s - rd_bin_s;
    afull_next_s   = (level_next_s >= AFULL_LVL);
  end

  // Pointer, status and memory-port registers.
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      wr_bin_r         <= '0;
      wr_ptr_gray_out  <= '0;
      fifo_full        <= 1'b0;
      fifo_almost_full <= 1'b0;
      wr_level         <= '0;
      mem_we           <= 1'b0;
      mem_waddr        <= '0;
      mem_wdata        <= '0;
    end else begin
      wr_bin_r         <= wr_bin_next_s;
      wr_ptr_gray_out  <= wr_gray_next_s;
      fifo_full        <= full_next_s;
      fifo_almost_full <= afull_next_s;
      wr_level         <= level_next_s;
      mem_we           <= accept_s;
      if (accept_s) begin
        mem_waddr <= wr_bin_r[ADDR_W-1:0];
        mem_wdata <= data_in;
      end
    end
  end

  // Sticky overflow; a refused write takes priority over the clear.
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (write_en && fifo_full) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// Scoreboard bench for cdc_fifo_wr_ctrl: expected memory writes are queued by the stimulus
// and popped by a monitor whenever mem_we is seen.
module tb_cdc_fifo_wr_ctrl;

  logic       clk_write = 1'b0;
  logic       rst;
  logic       write_en;
  logic [7:0] data_in;
  logic [4:0] rd_ptr_gray_in;
  logic       overflow_clr;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [4:0] wr_ptr_gray_out;
  logic       fifo_full;
  logic       fifo_almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [4:0] gray;
    logic [4:0] level;
    logic       full;
    logic       afull;
  } exp_t;

  exp_t exp_q[$];

  cdc_fifo_wr_ctrl #(
    .DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2), .AFULL_THRESH(12)
  ) dut (
    .clk_write       (clk_write),
    .rst             (rst),
    .write_en        (write_en),
    .data_in         (data_in),
    .rd_ptr_gray_in  (rd_ptr_gray_in),
    .overflow_clr    (overflow_clr),
    .mem_we          (mem_we),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata),
    .wr_ptr_gray_out (wr_ptr_gray_out),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .wr_level        (wr_level),
    .overflow        (overflow)
  );

  always #5 clk_write = ~clk_write;

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [7:0] d, input logic [4:0] g,
                          input logic [4:0] l, input logic f, input logic af);
    exp_t e;
    e.addr = a; e.data = d; e.gray = g; e.level = l; e.full = f; e.afull = af;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_write);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_we"},    32'(mem_we),           32'd0);
    chk({tag, "_waddr"},     32'(mem_waddr),        32'd0);
    chk({tag, "_wdata"},     32'(mem_wdata),        32'd0);
    chk({tag, "_gray"},      32'(wr_ptr_gray_out),  32'd0);
    chk({tag, "_full"},      32'(fifo_full),        32'd0);
    chk({tag, "_afull"},     32'(fifo_almost_full), 32'd0);
    chk({tag, "_level"},     32'(wr_level),         32'd0);
    chk({tag, "_overflow"},  32'(overflow),         32'd0);
  endtask

  // Monitor: every presented memory write must match the oldest expected entry.
  always @(negedge clk_write) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0d data=%0h required none at %0t",
                 mem_waddr, mem_wdata, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr",  32'(mem_waddr),        32'(e.addr));
        chk("wr_data",  32'(mem_wdata),        32'(e.data));
        chk("wr_gray",  32'(wr_ptr_gray_out),  32'(e.gray));
        chk("wr_level", 32'(wr_level),         32'(e.level));
        chk("wr_full",  32'(fifo_full),        32'(e.full));
        chk("wr_afull", 32'(fifo_almost_full), 32'(e.afull));
      end
    end
  end

  initial begin
    rst            = 1'b1;
    write_en       = 1'b1;
    data_in        = 8'h55;
    rd_ptr_gray_in = 5'd0;
    overflow_clr   = 1'b0;

    // Reset held three cycles with write_en high.
    #1;
    chk_all_zero("rst_t0");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("rst_hold");
    end
    write_en = 1'b0;
    rst      = 1'b0;
    tick();
    chk_all_zero("rst_after");

    // Fill from empty with the read pointer parked at 0.
    for (int n = 0; n < 16; n++) begin
      push_exp(4'(n), 8'(8'hA0 + n), gray5(5'(n + 1)), 5'(n + 1), (n == 15), (n + 1 >= 12));
      data_in  = 8'(8'hA0 + n);
      write_en = 1'b1;
      tick();
    end
    chk("fill_full",  32'(fifo_full),       32'd1);
    chk("fill_level", 32'(wr_level),        32'd16);
    chk("fill_gray",  32'(wr_ptr_gray_out), 32'h18);

    // Writes while full are dropped and set overflow.
    data_in = 8'hEE;
    tick();
    tick();
    write_en = 1'b0;
    chk("ovf_set",  32'(overflow),        32'd1);
    chk("ovf_gray", 32'(wr_ptr_gray_out), 32'h18);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    overflow_clr = 1'b1;
    write_en     = 1'b1;
    tick();
    overflow_clr = 1'b0;
    write_en     = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);

    // Read pointer jumps to 4; status follows three edges later.
    rd_ptr_gray_in = 5'b00110;
    tick();
    chk("drain_e1_full", 32'(fifo_full), 32'd1);
    tick();
    chk("drain_e2_full", 32'(fifo_full), 32'd1);
    tick();
    chk("drain_e3_full",  32'(fifo_full),        32'd0);
    chk("drain_e3_level", 32'(wr_level),         32'd12);
    chk("drain_e3_afull", 32'(fifo_almost_full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      push_exp(4'(k), 8'(8'hB0 + k), gray5(5'(17 + k)), 5'(13 + k), (k == 3), 1'b1);
      data_in  = 8'(8'hB0 + k);
      write_en = 1'b1;
      tick();
    end
    write_en = 1'b0;
    chk("refill_full", 32'(fifo_full), 32'd1);

    // Reset while full with overflow set clears every output without a clock edge.
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
    chk("pre_rst_full", 32'(fifo_full), 32'd1);
    chk("pre_rst_ovf",  32'(overflow),  32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    rd_ptr_gray_in = 5'd0;
    tick();
    rst = 1'b0;
    push_exp(4'd0, 8'hC3, 5'b00001, 5'd1, 1'b0, 1'b0);
    data_in  = 8'hC3;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
    tick();
    chk("post_rst_gray", 32'(wr_ptr_gray_out), 32'h01);

    // Wrap: 40 writes, read pointer trailing 2 behind; level settles at 4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int m = 1; m <= 40; m++) begin
      push_exp(4'((m - 1) % 16), 8'(m), gray5(5'(m)), 5'((m < 4) ? m : 4), 1'b0, 1'b0);
      data_in  = 8'(m);
      write_en = 1'b1;
      tick();
      write_en       = 1'b0;
      rd_ptr_gray_in = gray5(5'((m >= 2) ? (m - 2) : 0));
      tick();
      if (m == 31) chk("wrap_gray31", 32'(wr_ptr_gray_out), 32'h10);
      if (m == 32) chk("wrap_gray32", 32'(wr_ptr_gray_out), 32'h00);
    end

    tick();
    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
